nem_ohmux_sel_seq: RTL and testbench
====================================

Name: nem_ohmux_sel_seq

Overview:
- Upstream select sequencer for the NEM one-hot inverting mux banks.
- Converts a binary select request into the registered one-hot select vector S that drives the mux.
- Enforces break-before-make on the relays: all selects are released for a release dead-time before the new select is asserted.
- Flags the output stable only after the relay pull-in time has elapsed, so downstream logic samples ZN only when the selected path is closed.

Parameters:
- NUM_IN, 2, number of one-hot select lines (mux inputs); range 2..16.
- SEL_W, 1, width of the binary select index; must satisfy 2^SEL_W >= NUM_IN.
- BREAK_CYC, 4, relay release dead-time in CP cycles; minimum 1.
- MAKE_CYC, 8, relay pull-in settle time in CP cycles; minimum 1.
- CNT_W, 8, settle counter width; must hold max(BREAK_CYC, MAKE_CYC).

Ports:
- CP  input  1  clock, rising edge.
- CDN  input  1  asynchronous active-low reset.
- req_valid  input  1  select change request.
- req_off  input  1  with req_valid: open all relays; req_sel is ignored.
- req_sel  input  SEL_W  requested input index.
- req_ready  output  1  request accepted on a CP edge where req_valid && req_ready.
- S  output  NUM_IN  one-hot-or-zero relay select, registered.
- cur_sel  output  SEL_W  index currently asserted or being made.
- sel_on  output  1  a select line is asserted in S.
- sel_stable  output  1  S is settled; downstream ZN is valid.
- busy  output  1  a BREAK or MAKE sequence is in progress.
- err  output  1  one-cycle pulse when an out-of-range request is accepted.

Behaviour:
- Reset: CDN low asynchronously forces S=0, cur_sel=0, sel_on=0, sel_stable=1, busy=0, err=0, req_ready=1, counter=0, state=OFF. Reset during BREAK or MAKE aborts the sequence immediately; S never glitches high.
- States:
  - OFF: S=0; sel_stable=1; req_ready=1.
  - BREAK: S=0; counts BREAK_CYC cycles.
  - MAKE: S=onehot(cur_sel); counts MAKE_CYC cycles.
  - HOLD: S=onehot(cur_sel); sel_stable=1; req_ready=1.
- req_ready=1 only in OFF and HOLD. Requests presented in BREAK or MAKE are not accepted; the requester must hold req_valid, req_off and req_sel stable until accepted.
- Accept rules, for a request accepted at edge t:
  - req_sel >= NUM_IN (and req_off=0): err=1 for the cycle after t; state, S and cur_sel are unchanged.
  - OFF, valid select: cur_sel=req_sel; S=onehot at t (no break, since nothing is closed); state MAKE.
  - HOLD, req_sel==cur_sel: no-op; S and sel_stable are unchanged.
  - HOLD, new valid select: S=0 at t; state BREAK; cur_sel updated at t.
  - HOLD, req_off: S=0 at t; state BREAK; ends in OFF.
  - OFF, req_off: no-op.
- BREAK lasts exactly BREAK_CYC cycles with S=0. It exits at edge t+BREAK_CYC:
  - to MAKE, with S=onehot(cur_sel);
  - or to OFF, if the request was req_off.
- MAKE lasts exactly MAKE_CYC cycles. At edge (MAKE entry + MAKE_CYC): state HOLD, sel_stable=1, req_ready=1.
- sel_stable=0 and busy=1 throughout BREAK and MAKE.
- sel_on=1 exactly in MAKE and HOLD.
- Invariant: popcount(S) <= 1 on every cycle. S never switches directly from one line to another.
- Counter: loaded on state entry, decrements to 0, and does not wrap. A terminal count of 0 transitions on that edge.
- All outputs are registered. There is no combinational path from req_* to S; req_ready depends only on state.

Test Plan (NUM_IN=2, BREAK_CYC=4, MAKE_CYC=8):
- Release CDN, then request sel=1 at edge 0 → S=2'b10 from edge 0; sel_stable=0 for edges 0–7; sel_stable=1 and req_ready=1 at edge 8.
- From HOLD sel=1, request sel=0 at edge 0 → S=00 for edges 0–3; S=01 at edge 4; sel_stable=1 at edge 12. popcount(S)<=1 on all cycles.
- HOLD sel=0, request req_off → S=00 at edge 0; busy=1 for 4 cycles; state OFF and sel_stable=1 at edge 4.
- Request sel=0 while already in HOLD sel=0 → no S change; sel_stable stays 1; busy stays 0.
- Request sel=2 (SEL_W=2 build, NUM_IN=3: sel=3) → err pulses for 1 cycle; S unchanged.
- Hold req_valid with sel=0 during a MAKE to sel=1 → not accepted until HOLD. Then a full break/make to sel=0 follows.
- Assert CDN low mid-MAKE (edge 3) → S=0 immediately, asynchronously. After release, state is OFF and sel_stable=1.

Source files
------------

// File: rtl/nem_ohmux_sel_seq_if.sv
// Request/status bundle between a select requester and the NEM one-hot mux select sequencer.
// The requester drives req_*; the sequencer drives the relay select and status flags.
interface nem_ohmux_sel_seq_if #(
  parameter int NUM_IN = 2,
  parameter int SEL_W  = 1
);
  logic              req_valid;
  logic              req_off;
  logic [SEL_W-1:0]  req_sel;
  logic              req_ready;
  logic [NUM_IN-1:0] S;
  logic [SEL_W-1:0]  cur_sel;
  logic              sel_on;
  logic              sel_stable;
  logic              busy;
  logic              err;

  modport master (
    output req_valid, req_off, req_sel,
    input  req_ready, S, cur_sel, sel_on, sel_stable, busy, err
  );

  modport slave (
    input  req_valid, req_off, req_sel,
    output req_ready, S, cur_sel, sel_on, sel_stable, busy, err
  );
endinterface

// File: rtl/nem_ohmux_sel_seq.sv
// Break-before-make select sequencer for NEM one-hot inverting mux relays: releases all
// selects for BREAK_CYC cycles, asserts the new one-hot select, and flags it stable after MAKE_CYC.
module nem_ohmux_sel_seq #(
  parameter int NUM_IN    = 2,
  parameter int SEL_W     = 1,
  parameter int BREAK_CYC = 4,
  parameter int MAKE_CYC  = 8,
  parameter int CNT_W     = 8
) (
  input logic                 CP,
  input logic                 CDN,
  nem_ohmux_sel_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_BREAK = 2'd1,
    ST_MAKE  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  // Counters are loaded with N-1 so that state entry plus N-1 decrements spans exactly N cycles.
  localparam logic [CNT_W-1:0] BREAK_LOAD = CNT_W'(BREAK_CYC - 1);
  localparam logic [CNT_W-1:0] MAKE_LOAD  = CNT_W'(MAKE_CYC - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SEL_W-1:0]  cur_sel_q, cur_sel_d;
  logic              off_pend_q, off_pend_d;
  logic              err_q, err_d;
  logic [NUM_IN-1:0] s_q, s_d;
  logic              sel_on_q, sel_on_d;
  logic              stable_q, stable_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;

  logic accept;
  logic bad_sel;

  assign accept  = bus.req_valid && ready_q;
  assign bad_sel = !bus.req_off && ({1'b0, bus.req_sel} >= (SEL_W + 1)'(NUM_IN));

  // State and registered outputs. Every output comes from a flop, so S cannot glitch
  // and there is no combinational path from req_* to any output.
  // NOTE: sequential state uses non-blocking (<=) so all flops update together on the edge.
  always_ff @(posedge CP or negedge CDN) begin
    if (!CDN) begin
      state_q    <= ST_OFF;
      cnt_q      <= '0;
      cur_sel_q  <= '0;
      off_pend_q <= 1'b0;
      err_q      <= 1'b0;
      s_q        <= '0;
      sel_on_q   <= 1'b0;
      stable_q   <= 1'b1;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_sel_q  <= cur_sel_d;
      off_pend_q <= off_pend_d;
      err_q      <= err_d;
      s_q        <= s_d;
      sel_on_q   <= sel_on_d;
      stable_q   <= stable_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
    end
  end

  // Next-state logic.
  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_sel_d  = cur_sel_q;
    off_pend_d = off_pend_q;
    err_d      = 1'b0;

    unique case (state_q)
      ST_OFF: begin
        if (accept) begin
          if (bad_sel) begin
            err_d = 1'b1;
          end else if (!bus.req_off) begin
            // Nothing is closed, so the new select can be made without a break.
            cur_sel_d = bus.req_sel;
            state_d   = ST_MAKE;
            cnt_d     = MAKE_LOAD;
          end
        end
      end
      ST_HOLD: begin
        if (accept) begin
          if (bad_sel) begin
            err_d = 1'b1;
          end else if (bus.req_off) begin
            state_d    = ST_BREAK;
            cnt_d      = BREAK_LOAD;
            off_pend_d = 1'b1;
          end else if (bus.req_sel != cur_sel_q) begin
            cur_sel_d  = bus.req_sel;
            state_d    = ST_BREAK;
            cnt_d      = BREAK_LOAD;
            off_pend_d = 1'b0;
          end
        end
      end
      ST_BREAK: begin
        if (cnt_q == '0) begin
          off_pend_d = 1'b0;
          if (off_pend_q) begin
            state_d = ST_OFF;
          end else begin
            state_d = ST_MAKE;
            cnt_d   = MAKE_LOAD;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_MAKE: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_OFF;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic: next values of the registered outputs, decoded from the next state.
  always_comb begin
    s_d      = '0;
    sel_on_d = (state_d == ST_MAKE) || (state_d == ST_HOLD);
    stable_d = (state_d == ST_OFF)  || (state_d == ST_HOLD);
    busy_d   = (state_d == ST_BREAK) || (state_d == ST_MAKE);
    ready_d  = stable_d;
    if (sel_on_d) begin
      for (int i = 0; i < NUM_IN; i++) begin
        s_d[i] = (cur_sel_d == SEL_W'(i));
      end
    end
  end

  assign bus.S          = s_q;
  assign bus.cur_sel    = cur_sel_q;
  assign bus.sel_on     = sel_on_q;
  assign bus.sel_stable = stable_q;
  assign bus.busy       = busy_q;
  assign bus.req_ready  = ready_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_nem_ohmux_sel_seq.sv
// Directed bench for nem_ohmux_sel_seq: a 2-input build driven from a vector table plus
// hand-written corner sequences, and a 3-input build for out-of-range requests.
module tb_nem_ohmux_sel_seq;

  logic CP;
  logic CDN;
  int   n_checks;
  int   n_errors;
  bit   mon_en;

  nem_ohmux_sel_seq_if #(.NUM_IN(2), .SEL_W(1)) bus2 ();
  nem_ohmux_sel_seq_if #(.NUM_IN(3), .SEL_W(2)) bus3 ();

  nem_ohmux_sel_seq #(
    .NUM_IN(2), .SEL_W(1), .BREAK_CYC(4), .MAKE_CYC(8), .CNT_W(8)
  ) dut (
    .CP  (CP),
    .CDN (CDN),
    .bus (bus2)
  );

  nem_ohmux_sel_seq #(
    .NUM_IN(3), .SEL_W(2), .BREAK_CYC(4), .MAKE_CYC(8), .CNT_W(8)
  ) dut3 (
    .CP  (CP),
    .CDN (CDN),
    .bus (bus3)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  // One vector: inputs applied before an edge, outputs expected just after it.
  typedef struct {
    logic       v;
    logic       off;
    logic       sel;
    logic [1:0] s;
    logic       cur;
    logic       on;
    logic       stable;
    logic       busy;
    logic       ready;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input int n, input logic v, input logic off, input logic sel,
                     input logic [1:0] s, input logic cur, input logic on,
                     input logic stable, input logic busy, input logic ready);
    vec_t r;
    r = '{v: v, off: off, sel: sel, s: s, cur: cur, on: on,
          stable: stable, busy: busy, ready: ready};
    for (int i = 0; i < n; i++) vecs.push_back(r);
  endtask

  task automatic step(input logic v, input logic off, input logic sel);
    @(negedge CP);
    bus2.req_valid = v;
    bus2.req_off   = off;
    bus2.req_sel   = sel;
    @(posedge CP);
    #1;
  endtask

  task automatic step3(input logic v, input logic off, input logic [1:0] sel);
    @(negedge CP);
    bus3.req_valid = v;
    bus3.req_off   = off;
    bus3.req_sel   = sel;
    @(posedge CP);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [1:0] s, input logic cur,
                           input logic on, input logic stable, input logic busy,
                           input logic ready);
    check({tag, ".S"},          32'(bus2.S),          32'(s));
    check({tag, ".cur_sel"},    32'(bus2.cur_sel),    32'(cur));
    check({tag, ".sel_on"},     32'(bus2.sel_on),     32'(on));
    check({tag, ".sel_stable"}, 32'(bus2.sel_stable), 32'(stable));
    check({tag, ".busy"},       32'(bus2.busy),       32'(busy));
    check({tag, ".req_ready"},  32'(bus2.req_ready),  32'(ready));
    check({tag, ".err"},        32'(bus2.err),        32'(0));
  endtask

  task automatic check_out3(input string tag, input logic [2:0] s, input logic [1:0] cur,
                            input logic stable, input logic ready, input logic err);
    check({tag, ".S"},          32'(bus3.S),          32'(s));
    check({tag, ".cur_sel"},    32'(bus3.cur_sel),    32'(cur));
    check({tag, ".sel_stable"}, 32'(bus3.sel_stable), 32'(stable));
    check({tag, ".req_ready"},  32'(bus3.req_ready),  32'(ready));
    check({tag, ".err"},        32'(bus3.err),        32'(err));
  endtask

  // At most one relay closed on every cycle, in both builds.
  always @(negedge CP) begin
    if (mon_en) begin
      check("popcount_S2", 32'($countones(bus2.S) <= 1), 32'(1));
      check("popcount_S3", 32'($countones(bus3.S) <= 1), 32'(1));
    end
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    mon_en   = 1'b0;
    CDN      = 1'b0;
    bus2.req_valid = 1'b0; bus2.req_off = 1'b0; bus2.req_sel = '0;
    bus3.req_valid = 1'b0; bus3.req_off = 1'b0; bus3.req_sel = '0;

    //   n  v off sel  S     cur on stb busy rdy
    // OFF -> sel=1: made at edge 0, stable at edge 8.
    add(1, 1, 0, 1, 2'b10, 1, 1, 0, 1, 0);
    add(7, 0, 0, 0, 2'b10, 1, 1, 0, 1, 0);
    add(1, 0, 0, 0, 2'b10, 1, 1, 1, 0, 1);
    // HOLD 1 -> sel=0: break edges 0-3, make at 4, stable at 12.
    add(1, 1, 0, 0, 2'b00, 0, 0, 0, 1, 0);
    add(3, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 2'b01, 0, 1, 0, 1, 0);
    add(7, 0, 0, 0, 2'b01, 0, 1, 0, 1, 0);
    add(1, 0, 0, 0, 2'b01, 0, 1, 1, 0, 1);
    // Same select again while holding: no-op.
    add(1, 1, 0, 0, 2'b01, 0, 1, 1, 0, 1);
    add(1, 0, 0, 0, 2'b01, 0, 1, 1, 0, 1);
    // HOLD 0 -> off: break for 4 cycles, then OFF.
    add(1, 1, 1, 0, 2'b00, 0, 0, 0, 1, 0);
    add(3, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 2'b00, 0, 0, 1, 0, 1);
    // Off while already off: no-op.
    add(1, 1, 1, 1, 2'b00, 0, 0, 1, 0, 1);

    #12;
    check_out("reset", 2'b00, 0, 0, 1, 0, 1);
    check_out3("reset3", 3'b000, 2'd0, 1, 1, 0);
    @(negedge CP);
    CDN    = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].v, vecs[i].off, vecs[i].sel);
      check_out($sformatf("vec%0d", i), vecs[i].s, vecs[i].cur, vecs[i].on,
                vecs[i].stable, vecs[i].busy, vecs[i].ready);
    end

    // Request sel=0 held during a MAKE to sel=1: refused until HOLD, then break/make.
    step(1, 0, 1);
    check_out("hold_make0", 2'b10, 1, 1, 0, 1, 0);
    for (int i = 1; i < 8; i++) begin
      step(1, 0, 0);
      check_out($sformatf("hold_make%0d", i), 2'b10, 1, 1, 0, 1, 0);
    end
    step(1, 0, 0);
    check_out("hold_reached", 2'b10, 1, 1, 1, 0, 1);
    step(1, 0, 0);
    check_out("hold_accept", 2'b00, 0, 0, 0, 1, 0);
    for (int i = 1; i < 4; i++) begin
      step(0, 0, 0);
      check_out($sformatf("hold_break%0d", i), 2'b00, 0, 0, 0, 1, 0);
    end
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0);
      check_out($sformatf("hold_remake%0d", i), 2'b01, 0, 1, 0, 1, 0);
    end
    step(0, 0, 0);
    check_out("hold_final", 2'b01, 0, 1, 1, 0, 1);

    // Reset asserted mid-MAKE drops S without a clock edge.
    @(negedge CP);
    CDN = 1'b0;
    #1;
    check_out("rst_hold", 2'b00, 0, 0, 1, 0, 1);
    @(negedge CP);
    CDN = 1'b1;
    step(1, 0, 1);
    check_out("rst_make0", 2'b10, 1, 1, 0, 1, 0);
    for (int i = 1; i <= 3; i++) step(0, 0, 0);
    #2;
    CDN = 1'b0;
    #1;
    check_out("rst_async", 2'b00, 0, 0, 1, 0, 1);
    @(negedge CP);
    CDN = 1'b1;
    step(0, 0, 0);
    check_out("rst_after", 2'b00, 0, 0, 1, 0, 1);

    // Out-of-range requests on the 3-input build.
    step3(1, 0, 2'd3);
    check_out3("oor_off", 3'b000, 2'd0, 1, 1, 1);
    step3(0, 0, 2'd0);
    check_out3("oor_off_clr", 3'b000, 2'd0, 1, 1, 0);
    step3(1, 0, 2'd2);
    check_out3("sel2_make", 3'b100, 2'd2, 0, 0, 0);
    for (int i = 1; i < 8; i++) step3(0, 0, 2'd0);
    step3(0, 0, 2'd0);
    check_out3("sel2_hold", 3'b100, 2'd2, 1, 1, 0);
    step3(1, 0, 2'd3);
    check_out3("oor_hold", 3'b100, 2'd2, 1, 1, 1);
    step3(0, 0, 2'd0);
    check_out3("oor_hold_clr", 3'b100, 2'd2, 1, 1, 0);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
